rmii_loop_dly: RTL and testbench
================================

RMII_LOOP_DLY -- requirements
Module: rmii_loop_dly

Interface
REQ-001 Parameter DW, default 2: data width per cycle; legal values 2 (RMII) and 4 (MII nibble).
REQ-002 Parameter DELAY, default 1: loop latency in refclk cycles; legal range 1..32.
REQ-003 Parameter CNT_W, default 16: width of the statistics counters.
REQ-004 refclk  in  1  single clock; every flop is rising-edge refclk.
REQ-005 rst_l  in  1  reset; asynchronous assert, active-low.
REQ-006 txd  in  DW  transmit data.
REQ-007 tx_en  in  1  transmit enable; high for the whole frame.
REQ-008 loop_en  in  1  1 = loop frames; 0 = discard frames at frame start.
REQ-009 inj_err  in  1  one-cycle pulse; arms error injection for the next looped frame.
REQ-010 drop_req  in  1  one-cycle pulse; arms discard of the next frame.
REQ-011 rxd  out  DW  looped data.
REQ-012 crs_dv  out  1  looped carrier/data valid.
REQ-013 rx_er  out  1  receive error; high only on injected cycles.
REQ-014 frame_cnt  out  CNT_W  number of frames delivered to rxd.
REQ-015 err_cnt  out  CNT_W  number of frames that carried an injected error.
REQ-016 busy  out  1  high while the FSM is not IDLE or the delay line holds any valid cycle.

Function
REQ-017 The input-side FSM SHALL have three states: IDLE, FRAME and DROP.
REQ-018 In IDLE with tx_en=1, the FSM SHALL go to DROP if loop_en=0 or drop is armed, and to FRAME otherwise.
REQ-019 From FRAME or DROP, the FSM SHALL return to IDLE on the first cycle with tx_en=0.
REQ-020 The delay line SHALL carry {valid, err, txd} per cycle. valid=tx_en in FRAME and in the IDLE->FRAME entry cycle; valid=0 in DROP and in IDLE without a start.
REQ-021 rxd, crs_dv and rx_er at cycle n+DELAY SHALL equal the delay-line entry written at cycle n; DELAY=1 gives single-register behaviour.
REQ-022 When the emerging entry has valid=0, rxd SHALL be 0 and crs_dv SHALL be 0.
REQ-023 Drop arming: drop_req=1 sets the drop arm. The arm is consumed only by a frame that enters DROP because of it; a frame discarded by loop_en=0 SHALL NOT consume it.
REQ-024 Error arming: inj_err=1 sets the err arm. The arm is consumed by the next frame entering FRAME; that frame's first valid entry gets err=1, and all other entries get err=0.
REQ-025 If both arms are set at frame start, drop SHALL win and the err arm SHALL remain set for the following looped frame.
REQ-026 A pulse arriving during FRAME or DROP SHALL apply to the next frame, never the current one. A pulse in the frame-start cycle SHALL apply to that frame.
REQ-027 frame_cnt SHALL increment on each IDLE->FRAME transition. err_cnt SHALL increment when the err arm is consumed. Both counters SHALL saturate at all-ones.
REQ-028 Back-to-back frames with a single idle cycle between them SHALL both be handled per REQ-018, with no lost cycles.
REQ-029 A DW value other than 2 or 4, or a DELAY value outside 1..32, SHALL cause an elaboration-time error.

Reset
REQ-030 While rst_l=0, and immediately on assertion, the following SHALL be forced: FSM=IDLE; both arms cleared; delay line all zero; rxd=0; crs_dv=0; rx_er=0; frame_cnt=0; err_cnt=0; busy=0.
REQ-031 Reset asserted mid-frame SHALL discard the frame. After release while tx_en=1, the FSM SHALL stay out of FRAME until tx_en has been 0 for at least one cycle.

Structure
REQ-032 Shared package rmii_loop_pkg SHALL hold the state enum and the legal-DW and DELAY-range constants.
REQ-033 The delay line SHALL be a separate sub-module, rmii_dly_line: a parametrised shift register with width DW+2 and depth DELAY, async active-low clear.

Verification
REQ-034 Pass-through: DW=2, DELAY=1, 8-cycle frame, txd=0,1,2,3,... -> identical rxd and crs_dv one cycle later; rx_er=0; frame_cnt=1.
REQ-035 Latency: DW=4, DELAY=7, single frame -> first crs_dv=1 exactly 7 cycles after first tx_en=1; rxd matches txd nibble for nibble.
REQ-036 Drop plus error: inj_err and drop_req pulsed together, then frames A and B -> A absent on outputs; B has rx_er=1 on its first cycle only; frame_cnt=1; err_cnt=1.
REQ-037 loop_en=0 during frame A, drop_req pulsed earlier, then loop_en=1 -> A discarded, next frame B also discarded (arm preserved), frame C delivered.
REQ-038 Reset mid-frame: rst_l low at frame cycle 3 -> all outputs 0 within the same cycle; after release with tx_en still 1, no crs_dv until a new frame starts.
REQ-039 Saturation: CNT_W=2, five frames -> frame_cnt stays at 3.

Source files
------------

// File: rtl/rmii_loop_pkg.sv
// rtl/rmii_loop_pkg.sv - shared state type and legal-parameter constants for the RMII loop delay
package rmii_loop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_DROP  = 2'd2
  } state_e;

  localparam int DW_RMII   = 2;
  localparam int DW_MII    = 4;
  localparam int DELAY_MIN = 1;
  localparam int DELAY_MAX = 32;

  function automatic logic dw_legal(input int dw);
    return (dw == DW_RMII) || (dw == DW_MII);
  endfunction

  function automatic logic delay_legal(input int dly);
    return (dly >= DELAY_MIN) && (dly <= DELAY_MAX);
  endfunction

endpackage

// File: rtl/rmii_dly_line.sv
// rtl/rmii_dly_line.sv - fixed-depth shift register with an occupancy flag taken from one bit of each stage
module rmii_dly_line #(
  parameter int W     = 4,
  parameter int DEPTH = 1,
  parameter int VBIT  = W - 1
) (
  input  logic         clk_i,
  input  logic         rst_l_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         occ_o
);

  logic [W-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_l_i) begin
    if (!rst_l_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign dout_o = stage_q[DEPTH-1];

  always_comb begin
    occ_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_o = occ_o | stage_q[i][VBIT];
    end
  end

endmodule

// File: rtl/rmii_loop_dly.sv
// rtl/rmii_loop_dly.sv - RMII/MII loopback with programmable latency, frame drop and error injection
module rmii_loop_dly
  import rmii_loop_pkg::*;
#(
  parameter int DW    = 2,
  parameter int DELAY = 1,
  parameter int CNT_W = 16
) (
  input  logic             refclk,
  input  logic             rst_l,
  input  logic [DW-1:0]    txd,
  input  logic             tx_en,
  input  logic             loop_en,
  input  logic             inj_err,
  input  logic             drop_req,
  output logic [DW-1:0]    rxd,
  output logic             crs_dv,
  output logic             rx_er,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             busy
);

  if (!dw_legal(DW)) begin : g_bad_dw
    $error("rmii_loop_dly: DW must be 2 or 4");
  end
  if (!delay_legal(DELAY)) begin : g_bad_delay
    $error("rmii_loop_dly: DELAY must be within 1..32");
  end

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  state_e           state_q, state_d;
  logic             drop_arm_q, drop_arm_d;
  logic             err_arm_q, err_arm_d;
  logic             idle_seen_q, idle_seen_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             entry_valid;
  logic             entry_err;
  logic [DW+1:0]    entry;
  logic [DW+1:0]    dly_out;
  logic             dly_occ;

  // Pulses always set their arm; only a frame start clears one, so pulses
  // mid-frame naturally carry over to the next frame.
  always_comb begin
    state_d     = state_q;
    drop_arm_d  = drop_arm_q | drop_req;
    err_arm_d   = err_arm_q | inj_err;
    idle_seen_d = idle_seen_q | ~tx_en;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    entry_valid = 1'b0;
    entry_err   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // idle_seen_q keeps a frame already in flight at reset release out of FRAME
        if (tx_en && idle_seen_q) begin
          if (!loop_en) begin
            state_d = ST_DROP;
          end else if (drop_arm_q || drop_req) begin
            state_d    = ST_DROP;
            drop_arm_d = 1'b0;
          end else begin
            state_d     = ST_FRAME;
            entry_valid = 1'b1;
            entry_err   = err_arm_q | inj_err;
            err_arm_d   = 1'b0;
            frame_cnt_d = sat_inc(frame_cnt_q);
            if (entry_err) begin
              err_cnt_d = sat_inc(err_cnt_q);
            end
          end
        end
      end
      ST_FRAME: begin
        if (!tx_en) begin
          state_d = ST_IDLE;
        end else begin
          entry_valid = 1'b1;
        end
      end
      ST_DROP: begin
        if (!tx_en) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge refclk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= ST_IDLE;
      drop_arm_q  <= 1'b0;
      err_arm_q   <= 1'b0;
      idle_seen_q <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      drop_arm_q  <= drop_arm_d;
      err_arm_q   <= err_arm_d;
      idle_seen_q <= idle_seen_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign entry = {entry_valid, entry_err, entry_valid ? txd : {DW{1'b0}}};

  rmii_dly_line #(
    .W     (DW + 2),
    .DEPTH (DELAY),
    .VBIT  (DW + 1)
  ) u_dly_line (
    .clk_i   (refclk),
    .rst_l_i (rst_l),
    .din_i   (entry),
    .dout_o  (dly_out),
    .occ_o   (dly_occ)
  );

  assign crs_dv    = dly_out[DW+1];
  assign rx_er     = dly_out[DW];
  assign rxd       = dly_out[DW-1:0];
  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign busy      = (state_q != ST_IDLE) | dly_occ;

endmodule

// File: tb/tb_rmii_loop_dly.sv
// tb/tb_rmii_loop_dly.sv - directed self-checking bench for rmii_loop_dly
module tb_rmii_loop_dly;

  logic       refclk = 1'b0;
  logic       rst_l;
  logic [3:0] txd;
  logic       tx_en, loop_en, inj_err, drop_req;

  logic [1:0]  rxd_a;
  logic        crs_dv_a, rx_er_a, busy_a;
  logic [15:0] frame_cnt_a, err_cnt_a;

  logic [3:0]  rxd_b;
  logic        crs_dv_b, rx_er_b, busy_b;
  logic [1:0]  frame_cnt_b, err_cnt_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 refclk = ~refclk;

  rmii_loop_dly #(.DW(2), .DELAY(1), .CNT_W(16)) u_dut_a (
    .refclk    (refclk),
    .rst_l     (rst_l),
    .txd       (txd[1:0]),
    .tx_en     (tx_en),
    .loop_en   (loop_en),
    .inj_err   (inj_err),
    .drop_req  (drop_req),
    .rxd       (rxd_a),
    .crs_dv    (crs_dv_a),
    .rx_er     (rx_er_a),
    .frame_cnt (frame_cnt_a),
    .err_cnt   (err_cnt_a),
    .busy      (busy_a)
  );

  rmii_loop_dly #(.DW(4), .DELAY(7), .CNT_W(2)) u_dut_b (
    .refclk    (refclk),
    .rst_l     (rst_l),
    .txd       (txd),
    .tx_en     (tx_en),
    .loop_en   (loop_en),
    .inj_err   (inj_err),
    .drop_req  (drop_req),
    .rxd       (rxd_b),
    .crs_dv    (crs_dv_b),
    .rx_er     (rx_er_b),
    .frame_cnt (frame_cnt_b),
    .err_cnt   (err_cnt_b),
    .busy      (busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic tx, input logic [3:0] d, input logic le,
                     input logic ie, input logic dr, input logic exp_crs, input logic exp_er);
    logic [1:0] d2;
    tx_en = tx; txd = d; loop_en = le; inj_err = ie; drop_req = dr;
    @(posedge refclk); #1;
    d2 = d[1:0];
    check({tag, "_crs"}, crs_dv_a, exp_crs);
    check({tag, "_er"},  rx_er_a,  exp_er);
    check({tag, "_rxd"}, rxd_a,    exp_crs ? d2 : 2'b00);
  endtask

  initial begin
    rst_l = 1'b0; tx_en = 1'b0; txd = '0; loop_en = 1'b1; inj_err = 1'b0; drop_req = 1'b0;
    repeat (2) @(posedge refclk);
    #1;
    check("rst_crs_a", crs_dv_a, 0);
    check("rst_rxd_a", rxd_a, 0);
    check("rst_fcnt_a", frame_cnt_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_crs_b", crs_dv_b, 0);
    rst_l = 1'b1;
    repeat (2) begin @(posedge refclk); #1; end

    // Pass-through on A, 7-cycle latency on B, same 8-cycle frame
    for (int i = 0; i < 16; i++) begin
      int j;
      logic vb;
      tx_en = (i < 8); txd = (i < 8) ? i[3:0] : 4'd0; loop_en = 1'b1; inj_err = 1'b0; drop_req = 1'b0;
      @(posedge refclk); #1;
      check("t1_a_crs", crs_dv_a, (i < 8) ? 1 : 0);
      check("t1_a_rxd", rxd_a, (i < 8) ? (i % 4) : 0);
      check("t1_a_er", rx_er_a, 0);
      j  = i - 6;
      vb = (j >= 0) && (j < 8);
      check("t1_b_crs", crs_dv_b, vb);
      check("t1_b_rxd", rxd_b, vb ? j : 0);
    end
    check("t1_fcnt_a", frame_cnt_a, 1);
    check("t1_fcnt_b", frame_cnt_b, 1);
    check("t1_ecnt_a", err_cnt_a, 0);
    check("t1_busy_a", busy_a, 0);
    check("t1_busy_b", busy_b, 0);

    // Drop + error armed together: A dropped, B carries the error on its first cycle
    cyc("t2_arm", 0, 0, 1, 1, 1, 0, 0);
    cyc("t2_A0", 1, 1, 1, 0, 0, 0, 0);
    check("t2_busy_drop", busy_a, 1);
    for (int k = 2; k <= 4; k++) cyc("t2_A", 1, k[3:0], 1, 0, 0, 0, 0);
    cyc("t2_gap", 0, 0, 1, 0, 0, 0, 0);
    cyc("t2_B0", 1, 5, 1, 0, 0, 1, 1);
    for (int k = 6; k <= 8; k++) cyc("t2_B", 1, k[3:0], 1, 0, 0, 1, 0);
    cyc("t2_end", 0, 0, 1, 0, 0, 0, 0);
    check("t2_fcnt_a", frame_cnt_a, 2);
    check("t2_ecnt_a", err_cnt_a, 1);
    check("t2_ecnt_b", err_cnt_b, 1);

    // loop_en=0 discard must not consume the drop arm
    cyc("t3_arm", 0, 0, 1, 0, 1, 0, 0);
    for (int k = 1; k <= 3; k++) cyc("t3_A", 1, k[3:0], 0, 0, 0, 0, 0);
    cyc("t3_gap1", 0, 0, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) cyc("t3_B", 1, k[3:0], 1, 0, 0, 0, 0);
    cyc("t3_gap2", 0, 0, 1, 0, 0, 0, 0);
    for (int k = 9; k <= 11; k++) cyc("t3_C", 1, k[3:0], 1, 0, 0, 1, 0);
    cyc("t3_end", 0, 0, 1, 0, 0, 0, 0);
    check("t3_fcnt_a", frame_cnt_a, 3);
    check("t3_fcnt_b", frame_cnt_b, 3);

    // Two more frames: B's 2-bit counter must hold at 3
    for (int f = 0; f < 2; f++) begin
      cyc("t4_f0", 1, 2, 1, 0, 0, 1, 0);
      cyc("t4_f1", 1, 3, 1, 0, 0, 1, 0);
      cyc("t4_gap", 0, 0, 1, 0, 0, 0, 0);
    end
    check("t4_fcnt_a", frame_cnt_a, 5);
    check("t4_fcnt_b_sat", frame_cnt_b, 3);

    // Reset at frame cycle 3
    for (int k = 1; k <= 3; k++) cyc("t5_pre", 1, k[3:0], 1, 0, 0, 1, 0);
    tx_en = 1'b1; txd = 4'd4;
    rst_l = 1'b0;
    #1;
    check("t5_rst_crs_a", crs_dv_a, 0);
    check("t5_rst_rxd_a", rxd_a, 0);
    check("t5_rst_fcnt_a", frame_cnt_a, 0);
    check("t5_rst_ecnt_a", err_cnt_a, 0);
    check("t5_rst_busy_a", busy_a, 0);
    check("t5_rst_crs_b", crs_dv_b, 0);
    check("t5_rst_busy_b", busy_b, 0);
    check("t5_rst_fcnt_b", frame_cnt_b, 0);
    @(posedge refclk); #1;
    rst_l = 1'b1;
    for (int k = 5; k <= 7; k++) cyc("t5_post", 1, k[3:0], 1, 0, 0, 0, 0);
    check("t5_post_busy", busy_a, 0);
    cyc("t5_gap", 0, 0, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) cyc("t5_new", 1, k[3:0], 1, 0, 0, 1, 0);
    cyc("t5_end", 0, 0, 1, 0, 0, 0, 0);
    check("t5_fcnt_a", frame_cnt_a, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
